// File: rtl/fc_vector_feeder.sv
// -----------------------------------------------------------------------------
// fc_vector_feeder
//
// Host-side driver for a streaming fully connected layer. The host loads an
// N-word input vector, then pulses start. The block streams the vector to the
// layer input port, collects M results from the layer output port into a
// result buffer, and pulses done when the run is finished.
//
// Optional feature macro: FEEDER_TIMEOUT_EN
//   defined   : an idle counter runs in RECV; after TIMEOUT cycles without a
//               result word the run is aborted with err=1 and done still pulses.
//   undefined : RECV waits indefinitely for M words; err is tied to 0.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   load_wr_en  in   vector write strobe (honoured in IDLE only)
//   load_addr   in   vector word index
//   load_data   in   signed vector word
//   start       in   begin a run (honoured in IDLE only)
//   busy        out  high in SEND and RECV
//   done        out  one-cycle pulse at end of run
//   err         out  sticky timeout flag, cleared by the next accepted start
//   s_valid     out  to layer input_valid
//   s_ready     in   from layer input_ready
//   s_data      out  to layer input_data (0 outside SEND)
//   r_valid     in   from layer output_valid
//   r_ready     out  to layer output_ready (high throughout RECV)
//   r_data      in   from layer output_data
//   rd_addr     in   result buffer read index
//   rd_data     out  registered result word, 1-cycle latency from rd_addr
// -----------------------------------------------------------------------------
module fc_vector_feeder #(
  parameter int M       = 16,
  parameter int N       = 8,
  parameter int T       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_wr_en,
  input  logic [$clog2(N)-1:0]    load_addr,
  input  logic signed [T-1:0]     load_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    s_valid,
  input  logic                    s_ready,
  output logic signed [T-1:0]     s_data,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic signed [T-1:0]     r_data,
  input  logic [$clog2(M)-1:0]    rd_addr,
  output logic signed [T-1:0]     rd_data
);

  localparam int NW = $clog2(N);
  localparam int MW = $clog2(M);

  // Terminal counts: the transfer at these indices ends the phase, so the
  // counters never need to wrap within a run.
  localparam logic [NW-1:0] SEND_LAST = NW'(N - 1);
  localparam logic [MW-1:0] RECV_LAST = MW'(M - 1);

  // Counter widths derive from $clog2, so single-entry buffers or a zero
  // timeout would collapse them to nothing; reject those at elaboration.
  if (N < 2 || M < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("fc_vector_feeder: N and M must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NW-1:0]           send_cnt_q, send_cnt_d;
  logic [MW-1:0]           recv_cnt_q, recv_cnt_d;
  logic signed [T-1:0]     vec_q [N];
  logic signed [T-1:0]     res_q [M];
  logic signed [T-1:0]     rd_data_q;

  logic                    vec_we_s;
  logic                    s_xfer_s;
  logic                    r_xfer_s;

`ifdef FEEDER_TIMEOUT_EN
  localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // idle_cnt_q counts consecutive RECV cycles without a result word; the run
  // aborts on the edge where it would reach TIMEOUT.
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [IW-1:0]           idle_cnt_q, idle_cnt_d;
  logic                    err_q, err_d;
`endif

  // The vector is only writable while idle, so it is stable during a run.
  assign vec_we_s = (state_q == S_IDLE) && load_wr_en;
  assign s_xfer_s = s_valid && s_ready;
  assign r_xfer_s = r_valid && r_ready;

  // Port decodes of the registered state; data path muxes the current word.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    s_valid = 1'b0;
    r_ready = 1'b0;
    s_data  = {T{1'b0}};
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_SEND: begin
        busy    = 1'b1;
        s_valid = 1'b1;
        s_data  = vec_q[send_cnt_q];
      end
      S_RECV: begin
        busy    = 1'b1;
        r_ready = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign rd_data = rd_data_q;

`ifdef FEEDER_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state and counter logic for the IDLE/SEND/RECV/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    send_cnt_d = send_cnt_q;
    recv_cnt_d = recv_cnt_q;
`ifdef FEEDER_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SEND;
          send_cnt_d = {NW{1'b0}};
          recv_cnt_d = {MW{1'b0}};
`ifdef FEEDER_TIMEOUT_EN
          idle_cnt_d = {IW{1'b0}};
          err_d      = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (s_xfer_s) begin
          if (send_cnt_q == SEND_LAST) begin
            state_d = S_RECV;
          end else begin
            send_cnt_d = send_cnt_q + NW'(1);
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_RECV: begin
        if (r_xfer_s) begin
          if (recv_cnt_q == RECV_LAST) begin
            state_d = S_DONE;
          end else begin
            recv_cnt_d = recv_cnt_q + MW'(1);
          end
`ifdef FEEDER_TIMEOUT_EN
          idle_cnt_d = {IW{1'b0}};
        end else if (idle_cnt_q == IDLE_LAST) begin
          // Layer went quiet: abort, flag it, and still signal completion.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
`else
        end else begin
          state_d = S_RECV;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and run counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      send_cnt_q <= {NW{1'b0}};
      recv_cnt_q <= {MW{1'b0}};
    end else begin
      state_q    <= state_d;
      send_cnt_q <= send_cnt_d;
      recv_cnt_q <= recv_cnt_d;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  // RECV idle counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= {IW{1'b0}};
      err_q      <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
    end
  end
`endif

  // Input vector storage; a write coinciding with start is committed first
  // and therefore streamed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= {T{1'b0}};
      end
    end else if (vec_we_s) begin
      vec_q[load_addr] <= load_data;
    end
  end

  // Result buffer; only words accepted during RECV are captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < M; i++) begin
        res_q[i] <= {T{1'b0}};
      end
    end else if (r_xfer_s) begin
      res_q[recv_cnt_q] <= r_data;
    end
  end

  // Registered read port, active in every state (old contents until written).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= {T{1'b0}};
    end else begin
      rd_data_q <= res_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_fc_vector_feeder.sv
// -----------------------------------------------------------------------------
// tb_fc_vector_feeder: directed self-checking bench for fc_vector_feeder.
// Inputs are driven on the falling edge and outputs sampled there too, so the
// rising edge always sees stable stimulus. A responder model plays the layer.
// -----------------------------------------------------------------------------
module tb_fc_vector_feeder;

  localparam int M  = 16;
  localparam int N  = 8;
  localparam int T  = 16;
  localparam int TO = 10;

  logic                 clk;
  logic                 reset;
  logic                 load_wr_en;
  logic [2:0]           load_addr;
  logic signed [T-1:0]  load_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [T-1:0]  s_data;
  logic                 r_valid;
  logic                 r_ready;
  logic signed [T-1:0]  r_data;
  logic [3:0]           rd_addr;
  logic signed [T-1:0]  rd_data;

  int checks;
  int errors;

  logic signed [T-1:0] sent_q [$];
  int                  hold_viol;

  fc_vector_feeder #(.M(M), .N(N), .T(T), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_wr_en (load_wr_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_vec(input int base);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      load_wr_en = 1'b1;
      load_addr  = 3'(i);
      load_data  = T'(base + i);
    end
    @(negedge clk);
    load_wr_en = 1'b0;
  endtask

  task automatic read_res(input int i, output logic signed [T-1:0] v);
    @(negedge clk);
    rd_addr = 4'(i);
    @(negedge clk);
    v = rd_data;
  endtask

  // One full run. n counts cycles after the start-sampling edge (n=1 is the
  // first SEND cycle). Responder returns rbase+k for result k, after rgap idle
  // cycles, stopping after rstop words. rdy_pat[(n-1)%4] drives s_ready.
  task automatic run_stream(input logic [3:0] rdy_pat, input int rgap, input bit rv_send,
                            input int rstop, input int rbase, input bit poke, input bit wr0,
                            output int n_done, output int n_busy, output int n_last,
                            output logic err_first, output logic err_done);
    int g, ridx;
    bit prev_pend;
    logic signed [T-1:0] prev_data;
    sent_q.delete();
    hold_viol = 0; n_done = 0; n_busy = 0; n_last = 0; g = 0; ridx = 0;
    prev_pend = 1'b0; prev_data = '0; err_first = 1'b0; err_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin
      load_wr_en = 1'b1; load_addr = 3'd0; load_data = -16'sd5;
    end
    @(negedge clk);
    start = 1'b0; load_wr_en = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1) err_first = err;
      if (done) begin
        n_done = n; err_done = err;
        break;
      end
      if (busy) n_busy++;
      if (poke && (n == 2 || n == 12)) begin
        start = 1'b1; load_wr_en = 1'b1; load_addr = 3'd3; load_data = 16'sd999;
      end else begin
        start = 1'b0; load_wr_en = 1'b0;
      end
      if (prev_pend && (!s_valid || s_data !== prev_data)) hold_viol++;
      s_ready = rdy_pat[(n - 1) % 4];
      if (s_valid && s_ready) sent_q.push_back(s_data);
      prev_pend = s_valid && !s_ready;
      prev_data = s_data;
      if (s_valid) begin
        r_valid = rv_send & n[0];
        r_data  = 16'sh7777;
      end else if (ridx < rstop && g >= rgap) begin
        r_valid = 1'b1;
        r_data  = T'(rbase + ridx);
        if (r_ready) begin
          ridx++; g = 0; n_last = n;
        end
      end else begin
        r_valid = 1'b0; r_data = '0; g++;
      end
    end
    s_ready = 1'b0; r_valid = 1'b0; r_data = '0; start = 1'b0; load_wr_en = 1'b0;
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL run_budget: done never seen within 400 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_wr_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    s_ready = 1'b0; r_valid = 1'b0; r_data = '0; rd_addr = '0;
    #1;
    checks++;
    if ({busy, done, err, s_valid, r_ready} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, s_valid, r_ready});
    end
    checks++;
    if (s_data !== 16'sd0 || rd_data !== 16'sd0) begin
      errors++; $display("FAIL reset_data: s_data=%0d rd_data=%0d want 0", s_data, rd_data);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b s_valid=%b want 0", busy, s_valid);
    end
  endtask

  task automatic test_basic();
    int nd, nb, nl;
    logic ef, ed;
    logic signed [T-1:0] v;
    load_vec(1);
    run_stream(4'b1111, 0, 1'b0, 16, 100, 1'b0, 1'b0, nd, nb, nl, ef, ed);
    checks++;
    if (sent_q.size() != 8) begin
      errors++; $display("FAIL basic_count: got %0d words want 8", sent_q.size());
    end
    for (int i = 0; i < sent_q.size(); i++) begin
      checks++;
      if (sent_q[i] !== T'(i + 1)) begin
        errors++; $display("FAIL basic_s_data[%0d]: got %0d want %0d", i, sent_q[i], i + 1);
      end
    end
    checks++;
    if (nd != 25) begin errors++; $display("FAIL basic_done_lat: got %0d want 25", nd); end
    checks++;
    if (nb != 24) begin errors++; $display("FAIL basic_busy_len: got %0d want 24", nb); end
    checks++;
    if (ed !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", ed); end
    @(negedge clk);
    checks++;
    if ({done, busy, s_valid, r_ready} !== 4'b0000 || s_data !== 16'sd0) begin
      errors++; $display("FAIL basic_post_idle: ctrl=%b s_data=%0d want 0000/0", {done, busy, s_valid, r_ready}, s_data);
    end
    for (int i = 0; i < M; i++) begin
      read_res(i, v);
      checks++;
      if (v !== T'(100 + i)) begin errors++; $display("FAIL basic_res[%0d]: got %0d want %0d", i, v, 100 + i); end
    end
  endtask

  task automatic test_backpressure();
    int nd, nb, nl;
    logic ef, ed;
    run_stream(4'b1001, 0, 1'b0, 16, 100, 1'b0, 1'b0, nd, nb, nl, ef, ed);
    checks++;
    if (sent_q.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d words want 8", sent_q.size());
    end
    for (int i = 0; i < sent_q.size(); i++) begin
      checks++;
      if (sent_q[i] !== T'(i + 1)) begin
        errors++; $display("FAIL bp_s_data[%0d]: got %0d want %0d", i, sent_q[i], i + 1);
      end
    end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
    // transfers in cycles 1,4,5,8,9,12,13,16; RECV 17..32; DONE in 33
    checks++;
    if (nd != 33) begin errors++; $display("FAIL bp_done_lat: got %0d want 33", nd); end
  endtask

  task automatic test_gaps();
    int nd, nb, nl;
    logic ef, ed;
    logic signed [T-1:0] v;
    run_stream(4'b1111, 3, 1'b1, 16, 300, 1'b0, 1'b0, nd, nb, nl, ef, ed);
    // RECV starts at cycle 9; each word takes 4 cycles: last at 72, DONE 73
    checks++;
    if (nd != 73) begin errors++; $display("FAIL gap_done_lat: got %0d want 73", nd); end
    for (int i = 0; i < M; i++) begin
      read_res(i, v);
      checks++;
      if (v !== T'(300 + i)) begin errors++; $display("FAIL gap_res[%0d]: got %0d want %0d", i, v, 300 + i); end
    end
  endtask

  task automatic test_ignore_busy();
    int nd, nb, nl;
    logic ef, ed;
    logic signed [T-1:0] exp_v;
    run_stream(4'b1111, 0, 1'b0, 16, 100, 1'b1, 1'b1, nd, nb, nl, ef, ed);
    checks++;
    if (sent_q.size() != 8) begin
      errors++; $display("FAIL ign_count: got %0d words want 8", sent_q.size());
    end
    for (int i = 0; i < sent_q.size(); i++) begin
      exp_v = (i == 0) ? -16'sd5 : T'(i + 1);
      checks++;
      if (sent_q[i] !== exp_v) begin
        errors++; $display("FAIL ign_s_data[%0d]: got %0d want %0d", i, sent_q[i], exp_v);
      end
    end
    checks++;
    if (nd != 25) begin errors++; $display("FAIL ign_done_lat: got %0d want 25", nd); end
  endtask

  task automatic test_reset_mid();
    int nd, nb, nl;
    logic ef, ed;
    logic signed [T-1:0] v;
    load_vec(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 16'sd5) begin
      errors++; $display("FAIL mid_progress: s_valid=%b s_data=%0d want 1/5", s_valid, s_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, s_valid, r_ready} !== 5'b00000 || s_data !== 16'sd0 || rd_data !== 16'sd0) begin
      errors++; $display("FAIL mid_async_reset: ctrl=%b s_data=%0d rd_data=%0d want 0", {busy, done, err, s_valid, r_ready}, s_data, rd_data);
    end
    s_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    read_res(7, v);
    checks++;
    if (v !== 16'sd0) begin errors++; $display("FAIL mid_res_clear: got %0d want 0", v); end
    run_stream(4'b1111, 0, 1'b0, 16, 500, 1'b0, 1'b0, nd, nb, nl, ef, ed);
    for (int i = 0; i < sent_q.size(); i++) begin
      checks++;
      if (sent_q[i] !== 16'sd0) begin errors++; $display("FAIL mid_vec_clear[%0d]: got %0d want 0", i, sent_q[i]); end
    end
    load_vec(11);
    run_stream(4'b1111, 0, 1'b0, 16, 100, 1'b0, 1'b0, nd, nb, nl, ef, ed);
    checks++;
    if (sent_q.size() != 8 || sent_q[7] !== 16'sd18 || sent_q[0] !== 16'sd11) begin
      errors++; $display("FAIL mid_fresh_run: %0d words, last word wrong or missing, want 11..18", sent_q.size());
    end
    checks++;
    if (nd != 25) begin errors++; $display("FAIL mid_fresh_lat: got %0d want 25", nd); end
  endtask

`ifdef FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int nd, nb, nl;
    logic ef, ed;
    logic signed [T-1:0] v;
    run_stream(4'b1111, 0, 1'b0, 5, 200, 1'b0, 1'b0, nd, nb, nl, ef, ed);
    checks++;
    if (ed !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", ed); end
    // last transfer on the edge ending cycle nl; DONE begins TIMEOUT edges later
    checks++;
    if (nd - 1 - nl != TO) begin errors++; $display("FAIL to_lat: got %0d want %0d", nd - 1 - nl, TO); end
    for (int i = 0; i < M; i++) begin
      read_res(i, v);
      checks++;
      if (v !== T'((i < 5) ? 200 + i : 100 + i)) begin
        errors++; $display("FAIL to_res[%0d]: got %0d want %0d", i, v, (i < 5) ? 200 + i : 100 + i);
      end
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err); end
    run_stream(4'b1111, 0, 1'b0, 16, 100, 1'b0, 1'b0, nd, nb, nl, ef, ed);
    checks++;
    if (ef !== 1'b0 || ed !== 1'b0) begin
      errors++; $display("FAIL to_clear: err first=%b done=%b want 0/0", ef, ed);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_ignore_busy();
    test_reset_mid();
`ifdef FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
